// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry valid/ready pipeline stage with a fully
// registered upstream ready. The main entry drives o_data. The skid entry
// absorbs the one word that can arrive in the same cycle the consumer stalls.
// Optional feature: define PIPE_FLUSH_EN to add the i_flush port, which
// discards every held word at the next clock edge.
module pipe_skid_stage #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
`ifdef PIPE_FLUSH_EN
    ,
    input  logic             i_flush
`endif
);

    // Occupancy: EMPTY = no word, BUSY = main only, FULL = main + skid.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             o_valid_r;
    logic             o_ready_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             flush_s;

`ifdef PIPE_FLUSH_EN
    assign flush_s = i_flush;
`else
    assign flush_s = 1'b0;
`endif

    // Handshakes use only the registered flags, so no input-to-output comb path.
    assign in_fire_s  = i_valid & o_ready_r;
    assign out_fire_s = o_valid_r & i_ready;

    assign o_ready = o_ready_r;
    assign o_valid = o_valid_r;
    assign o_data  = main_r;

    // Next-state and entry update; flush overrides every handshake outcome.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush_s) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = RESET_DATA;
            skid_nxt_s  = RESET_DATA;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_nxt_s  = i_data;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire_s && out_fire_s) begin
                        main_nxt_s  = i_data;
                        state_nxt_s = ST_BUSY;
                    end else if (in_fire_s) begin
                        // Consumer stalled: park the newcomer behind main.
                        skid_nxt_s  = i_data;
                        state_nxt_s = ST_FULL;
                    end else if (out_fire_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // o_ready is low here, so only the output side can move.
                    if (out_fire_s) begin
                        main_nxt_s  = skid_r;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State and handshake flags; flags are precomputed from the next state
    // so that both outputs come straight from flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_EMPTY;
            o_valid_r <= 1'b0;
            o_ready_r <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            o_valid_r <= (state_nxt_s == ST_BUSY) || (state_nxt_s == ST_FULL);
            o_ready_r <= (state_nxt_s != ST_FULL);
        end
    end

    // Data entries; they carry no control meaning, so only their load values matter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_r <= RESET_DATA;
            skid_r <= RESET_DATA;
        end else begin
            main_r <= main_nxt_s;
            skid_r <= skid_nxt_s;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: scoreboard bench for pipe_skid_stage. The reference
// model treats the stage as a two-word FIFO. ready means fewer than two
// words are held. valid means at least one word is held. o_data is the
// oldest word, or else the last word delivered (RESET_DATA after
// reset/flush). Define PIPE_FLUSH_EN to exercise the flush path.
module tb_pipe_skid_stage;

    localparam int          W          = 32;
    localparam logic [31:0] RESET_DATA = 32'h0000_0000;

    logic          clk;
    logic          resetn;
    logic          i_valid;
    logic [W-1:0]  i_data;
    logic          o_ready;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic          i_ready;
    logic          i_flush;

    pipe_skid_stage #(.WIDTH(W), .RESET_DATA(RESET_DATA)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
`ifdef PIPE_FLUSH_EN
        ,
        .i_flush (i_flush)
`endif
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   idle_data  = RESET_DATA;
    logic          pend_valid = 1'b0;
    logic [31:0]   pend_data  = 32'h0;
    logic          flush_pend = 1'b0;
    logic          mon_en     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply to the model whatever the previous clock edge did.
    task automatic commit();
        if (flush_pend) begin
            exp_q.delete();
            idle_data = RESET_DATA;
        end else if (pend_valid) begin
            exp_q.push_back(pend_data);
        end
        flush_pend = 1'b0;
        pend_valid = 1'b0;
    endtask

    // One cycle of stimulus, driven on the falling edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        @(negedge clk);
        commit();
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        if (f) begin
            flush_pend = 1'b1;
        end else if (v && exp_q.size() < 2) begin
            pend_valid = 1'b1;
            pend_data  = d;
        end
    endtask

    // Pull reset low between edges while the stage holds words.
    task automatic async_reset();
        @(negedge clk);
        commit();
        mon_en = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        i_ready = 1'b0;
        i_flush = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_o_valid", {31'h0, o_valid}, 32'h0);
        chk("async_rst_o_ready", {31'h0, o_ready}, 32'h1);
        chk("async_rst_o_data", o_data, RESET_DATA);
        exp_q.delete();
        idle_data = RESET_DATA;
        pend_valid = 1'b0;
        flush_pend = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hold_o_valid", {31'h0, o_valid}, 32'h0);
        i_valid = 1'b0;
        resetn  = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Monitor: compare outputs with the model, pop words the consumer takes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("o_valid", {31'h0, o_valid}, {31'h0, exp_q.size() != 0});
                chk("o_ready", {31'h0, o_ready}, {31'h0, exp_q.size() < 2});
                if (exp_q.size() > 0) begin
                    chk("o_data", o_data, exp_q[0]);
                    if (i_ready) begin
                        idle_data = exp_q.pop_front();
                    end
                end else begin
                    chk("o_data_idle", o_data, idle_data);
                end
            end
        end
    end

    initial begin
        logic f;
        resetn  = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEAD_BEEF;
        i_ready = 1'b0;
        i_flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_o_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_o_ready", {31'h0, o_ready}, 32'h1);
        chk("rst_o_data", o_data, RESET_DATA);
        @(negedge clk);
        i_valid = 1'b0;
        resetn  = 1'b1;
        mon_en  = 1'b1;

        // First word after reset.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Streaming at full rate.
        for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Stall into the skid entry, then recover.
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'hC, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Drain a single word.
        step(1'b1, 32'h55, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef PIPE_FLUSH_EN
        // Flush a full stage while a new word is offered.
        step(1'b1, 32'h10, 1'b0, 1'b0);
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h12, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
`endif

        // Asynchronous reset while stalled and full.
        step(1'b1, 32'h20, 1'b0, 1'b0);
        step(1'b1, 32'h21, 1'b0, 1'b0);
        async_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            f = 1'b0;
`ifdef PIPE_FLUSH_EN
            f = ($urandom_range(0, 31) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, f);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
